// File: rtl/mmio_timer.sv
// ---------------------------------------------------------------------------
// mmio_timer
//   Memory-mapped timer peripheral on the CPU data-memory port. Decodes a
//   32-byte window at BASE_ADDR, answers reads with one cycle of registered
//   latency (like main memory), and runs a compare/auto-reload counter that
//   raises a level interrupt.
//
//   Register map (word offsets):
//     0 CTRL     [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
//     1 COUNT    32-bit counter
//     2 COMPARE  32-bit compare value
//     3 STATUS   [0] MATCH, [1] WRAP (sticky, write-1-to-clear)
//     4 PRESCALE [15:0] tick divider (only with MMIO_TIMER_PRESCALE_EN)
//     other offsets read 0, writes ignored
//
//   Optional feature: define MMIO_TIMER_PRESCALE_EN to add the PRESCALE
//   register and divider; otherwise the counter ticks every cycle EN is set.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-low reset
//   address  in   32  byte address from the CPU
//   wr       in   1   write strobe
//   datain   in   32  write data
//   dataout  out  32  registered read data
//   hit      out  1   registered: dataout belongs to this block
//   irq      out  1   level interrupt request
// ---------------------------------------------------------------------------
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic        wr,
    input  logic [31:0] datain,
    output logic [31:0] dataout,
    output logic        hit,
    output logic        irq
);

    localparam logic [2:0] OFF_CTRL     = 3'd0;
    localparam logic [2:0] OFF_COUNT    = 3'd1;
    localparam logic [2:0] OFF_COMPARE  = 3'd2;
    localparam logic [2:0] OFF_STATUS   = 3'd3;
    localparam logic [2:0] OFF_PRESCALE = 3'd4;

    // Byte-lane bits are ignored by the decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[1:0];

    logic       sel;
    logic [2:0] off;
    assign sel = (address[31:5] == BASE_ADDR[31:5]);
    assign off = address[4:2];

    logic wr_ctrl, wr_count, wr_compare, wr_status;
    assign wr_ctrl    = sel & wr & (off == OFF_CTRL);
    assign wr_count   = sel & wr & (off == OFF_COUNT);
    assign wr_compare = sel & wr & (off == OFF_COMPARE);
    assign wr_status  = sel & wr & (off == OFF_STATUS);

    logic [2:0]  ctrl_q,    ctrl_d;
    logic [31:0] count_q,   count_d;
    logic [31:0] compare_q, compare_d;
    logic [1:0]  status_q,  status_d;
    logic [31:0] dataout_q, dataout_d;
    logic        hit_q,     hit_d;

    logic tick;

`ifdef MMIO_TIMER_PRESCALE_EN
    logic        wr_prescale;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] div_q,      div_d;

    assign wr_prescale = sel & wr & (off == OFF_PRESCALE);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        prescale_d = wr_prescale ? datain[15:0] : prescale_q;
        tick       = ctrl_q[0] && (div_q == prescale_q);
        if (!ctrl_q[0] || wr_prescale) begin
            div_d = 16'd0;
        end else if (div_q == prescale_q) begin
            div_d = 16'd0;
        end else begin
            div_d = div_q + 16'd1;
        end
    end
`else
    assign tick = ctrl_q[0];
`endif

    // Counter, one-shot and sticky status flags.
    logic match_set, wrap_set, en_clear;

    always_comb begin
        count_d   = count_q;
        match_set = 1'b0;
        wrap_set  = 1'b0;
        en_clear  = 1'b0;
        if (wr_count) begin
            // A software load wins; no compare is evaluated this cycle.
            count_d = datain;
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                if (ctrl_q[1]) begin
                    count_d = 32'd0;
                end else begin
                    count_d  = count_q + 32'd1;
                    en_clear = 1'b1;
                end
            end else if (count_q == 32'hFFFF_FFFF) begin
                count_d  = 32'd0;
                wrap_set = 1'b1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        ctrl_d = ctrl_q;
        if (wr_ctrl) begin
            ctrl_d = datain[2:0];
        end else if (en_clear) begin
            ctrl_d[0] = 1'b0;
        end

        compare_d = wr_compare ? datain : compare_q;

        // Clear first, then set, so a hardware event beats a same-cycle W1C.
        status_d = status_q;
        if (wr_status) begin
            status_d = status_d & ~datain[1:0];
        end
        status_d = status_d | {wrap_set, match_set};
    end

    // Read path: register the pre-edge value of the addressed register.
    always_comb begin
        dataout_d = 32'd0;
        hit_d     = sel;
        if (sel) begin
            case (off)
                OFF_CTRL:     dataout_d = {29'd0, ctrl_q};
                OFF_COUNT:    dataout_d = count_q;
                OFF_COMPARE:  dataout_d = compare_q;
                OFF_STATUS:   dataout_d = {30'd0, status_q};
`ifdef MMIO_TIMER_PRESCALE_EN
                OFF_PRESCALE: dataout_d = {16'd0, prescale_q};
`endif
                default:      dataout_d = 32'd0;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q    <= 3'd0;
            count_q   <= 32'd0;
            compare_q <= CMP_RESET;
            status_q  <= 2'd0;
            dataout_q <= 32'd0;
            hit_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            dataout_q <= dataout_d;
            hit_q     <= hit_d;
        end
    end

`ifdef MMIO_TIMER_PRESCALE_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q <= 16'd0;
            div_q      <= 16'd0;
        end else begin
            prescale_q <= prescale_d;
            div_q      <= div_d;
        end
    end
`endif

    assign dataout = dataout_q;
    assign hit     = hit_q;
    // Derived only from flops, so the interrupt line cannot glitch.
    assign irq     = ctrl_q[2] & (status_q[0] | status_q[1]);

endmodule

// File: tb/tb_mmio_timer.sv
module tb_mmio_timer;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic        wr;
    logic [31:0] datain;
    logic [31:0] dataout;
    logic        hit;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] IDLE = 32'h0000_0000;

    mmio_timer dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .wr      (wr),
        .datain  (datain),
        .dataout (dataout),
        .hit     (hit),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        logic        exp_hit;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] ed, input logic eh, input logic ei);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d;
        v.exp_data = ed; v.exp_hit = eh; v.exp_irq = ei;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, clock, then sample 1 ns after the edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        address = a; wr = 1'b1; datain = d;
        @(posedge clk); #1;
        address = IDLE; wr = 1'b0; datain = 32'd0;
    endtask

    task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        address = a; wr = 1'b0;
        @(posedge clk); #1;
        check(name, dataout, exp);
        address = IDLE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; address = IDLE; wr = 1'b0; datain = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst dataout", dataout, 32'd0);
        check("rst hit", {31'd0, hit}, 32'd0);
        check("rst irq", {31'd0, irq}, 32'd0);
        reset = 1'b1;

        // Reset values, decode, then auto-reload and one-shot runs.
        add(32'h400, 0, 0, 32'h0,         1, 0);
        add(32'h404, 0, 0, 32'h0,         1, 0);
        add(32'h408, 0, 0, 32'hFFFF_FFFF, 1, 0);
        add(32'h40C, 0, 0, 32'h0,         1, 0);
        add(32'h414, 0, 0, 32'h0,         1, 0);
        add(32'h420, 0, 0, 32'h0,         0, 0);
        add(32'h414, 1, 32'hDEAD_BEEF, 32'h0, 1, 0);
        add(32'h414, 0, 0, 32'h0,         1, 0);
        add(32'h408, 1, 32'd5, 32'hFFFF_FFFF, 1, 0);
        add(32'h408, 0, 0, 32'd5,         1, 0);
        add(32'h400, 1, 32'd7, 32'd0,     1, 0);
        add(32'h404, 0, 0, 32'd0,         1, 0);
        add(32'h404, 0, 0, 32'd1,         1, 0);
        add(32'h404, 0, 0, 32'd2,         1, 0);
        add(32'h404, 0, 0, 32'd3,         1, 0);
        add(32'h404, 0, 0, 32'd4,         1, 0);
        add(32'h404, 0, 0, 32'd5,         1, 1);
        add(32'h404, 0, 0, 32'd0,         1, 1);
        add(32'h40C, 0, 0, 32'd1,         1, 1);
        add(32'h40C, 1, 32'd1, 32'd1,     1, 0);
        add(32'h404, 0, 0, 32'd3,         1, 0);
        add(32'h400, 1, 32'd0, 32'd7,     1, 0);
        add(32'h404, 0, 0, 32'd5,         1, 0);
        add(32'h404, 0, 0, 32'd5,         1, 0);
        add(32'h404, 1, 32'd0, 32'd5,     1, 0);
        add(32'h408, 1, 32'd3, 32'd5,     1, 0);
        add(32'h400, 1, 32'd1, 32'd0,     1, 0);
        add(32'h404, 0, 0, 32'd0,         1, 0);
        add(32'h404, 0, 0, 32'd1,         1, 0);
        add(32'h404, 0, 0, 32'd2,         1, 0);
        add(32'h404, 0, 0, 32'd3,         1, 0);
        add(32'h400, 0, 0, 32'd0,         1, 0);
        add(32'h404, 0, 0, 32'd4,         1, 0);
        add(32'h404, 0, 0, 32'd4,         1, 0);
        add(32'h40C, 0, 0, 32'd1,         1, 0);
        add(32'h40C, 1, 32'd3, 32'd1,     1, 0);
        add(32'h40C, 0, 0, 32'd0,         1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            address = vecs[i].addr; wr = vecs[i].wr; datain = vecs[i].wdata;
            @(posedge clk); #1;
            check($sformatf("vec%0d dataout", i), dataout, vecs[i].exp_data);
            check($sformatf("vec%0d hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
            address = IDLE; wr = 1'b0; datain = 32'd0;
        end

        // Wrap then one-shot match at COMPARE=0.
        bus_write(32'h408, 32'd0);
        bus_write(32'h404, 32'hFFFF_FFFE);
        bus_write(32'h400, 32'd1);
        bus_read("wrap cnt0", 32'h404, 32'hFFFF_FFFE);
        bus_read("wrap cnt1", 32'h404, 32'hFFFF_FFFF);
        bus_read("wrap cnt2", 32'h404, 32'd0);
        bus_read("wrap status", 32'h40C, 32'd3);
        bus_read("wrap ctrl", 32'h400, 32'd0);
        bus_read("wrap frozen", 32'h404, 32'd1);
        bus_write(32'h40C, 32'd3);

        // W1C of MATCH in the same cycle MATCH sets: the set wins.
        bus_write(32'h408, 32'd2);
        bus_write(32'h404, 32'd0);
        bus_write(32'h400, 32'd3);
        bus_read("race cnt0", 32'h404, 32'd0);
        bus_read("race cnt1", 32'h404, 32'd1);
        bus_write(32'h40C, 32'd1);
        bus_read("race status", 32'h40C, 32'd1);
        bus_write(32'h400, 32'd0);
        bus_write(32'h40C, 32'd1);
        bus_read("race cleared", 32'h40C, 32'd0);

        // COUNT write while counting beats the increment.
        bus_write(32'h408, 32'd1000);
        bus_write(32'h400, 32'd1);
        bus_write(32'h404, 32'd100);
        bus_read("load 100", 32'h404, 32'd100);
        bus_read("load 101", 32'h404, 32'd101);
        bus_write(32'h400, 32'd0);

        // Asynchronous reset in the middle of a run with irq asserted.
        bus_write(32'h408, 32'd3);
        bus_write(32'h404, 32'd0);
        bus_write(32'h400, 32'd7);
        bus_read("run cnt0", 32'h404, 32'd0);
        bus_read("run cnt1", 32'h404, 32'd1);
        bus_read("run cnt2", 32'h404, 32'd2);
        bus_read("run cnt3", 32'h404, 32'd3);
        check("run irq", {31'd0, irq}, 32'd1);
        bus_read("run cnt4", 32'h404, 32'd0);
        address = 32'h404;
        @(posedge clk); #1;
        check("pre-rst dataout", dataout, 32'd1);
        check("pre-rst hit", {31'd0, hit}, 32'd1);
        reset = 1'b0;
        #1;
        check("async dataout", dataout, 32'd0);
        check("async hit", {31'd0, hit}, 32'd0);
        check("async irq", {31'd0, irq}, 32'd0);
        address = IDLE;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus_read("post compare", 32'h408, 32'hFFFF_FFFF);
        bus_read("post cnt0", 32'h404, 32'd0);
        bus_read("post cnt1", 32'h404, 32'd0);
        bus_read("post ctrl", 32'h400, 32'd0);
        bus_read("post status", 32'h40C, 32'd0);

`ifdef MMIO_TIMER_PRESCALE_EN
        // PRESCALE=2: one tick every third cycle.
        bus_write(32'h410, 32'd2);
        bus_write(32'h400, 32'd1);
        bus_read("psc c0", 32'h404, 32'd0);
        bus_read("psc c1", 32'h404, 32'd0);
        bus_read("psc c2", 32'h404, 32'd0);
        bus_read("psc c3", 32'h404, 32'd1);
        bus_read("psc c4", 32'h404, 32'd1);
        bus_read("psc c5", 32'h404, 32'd1);
        bus_read("psc c6", 32'h404, 32'd2);
        bus_read("psc reg", 32'h410, 32'd2);
`else
        bus_write(32'h410, 32'd2);
        bus_read("off4 reads 0", 32'h410, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
